// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10,
        S_ERR  = 2'b11
    } state_e;

    localparam logic RW_LOAD  = 1'b0;
    localparam logic RW_STORE = 1'b1;

endpackage

// File: rtl/dmem_if.sv
// Word-wide memory bus with req/ack handshake between controller and memory.
interface dmem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane steering: store strobes/replication, load extraction/extension,
// and the alignment/size legality check.
module dmem_lane
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic        load_un,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        bad
);
    logic [31:0] sh_b;
    logic [31:0] sh_h;

    always_comb begin
        wstrb     = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        bad       = 1'b0;
        sh_b      = rdata >> {off, 3'b000};
        sh_h      = rdata >> {off[1], 4'b0000};
        case (size)
            SZ_BYTE: begin
                wstrb     = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~load_un & sh_b[7]}}, sh_b[7:0]};
            end
            SZ_HALF: begin
                wstrb     = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~load_un & sh_h[15]}}, sh_h[15:0]};
                bad       = off[0];
            end
            SZ_WORD: begin
                wstrb     = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
                bad       = (off != 2'b00);
            end
            default: bad = 1'b1;
        endcase
    end
endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage access controller: sequences one load/store over the memory bus,
// stalls the pipeline meanwhile, and reports misaligned/illegal/timeout errors.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_rw,
    input  logic [1:0]  access_size,
    input  logic        load_un,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rsp_valid,
    output logic        err,
    output logic        stall,
    dmem_if.master      mem
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state, state_n;
    logic [7:0]  cnt;
    size_e       size_q;
    logic [1:0]  off_q;
    logic        un_q;
    logic        rw_q;

    size_e       lane_size;
    logic [1:0]  lane_off;
    logic        lane_un;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        lane_bad;

    // One lane instance serves both phases: live request fields in IDLE,
    // latched fields while the access is outstanding.
    assign lane_size = (state == S_IDLE) ? size_e'(access_size) : size_q;
    assign lane_off  = (state == S_IDLE) ? addr[1:0] : off_q;
    assign lane_un   = (state == S_IDLE) ? load_un : un_q;

    dmem_lane u_lane (
        .size      (lane_size),
        .off       (lane_off),
        .load_un   (lane_un),
        .wdata     (wdata),
        .rdata     (mem.mem_rdata),
        .wstrb     (lane_wstrb),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata),
        .bad       (lane_bad)
    );

    assign req_ready = (state == S_IDLE);
    assign stall     = req_valid & ~rsp_valid;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (req_valid) state_n = lane_bad ? S_ERR : S_BUSY;
            S_BUSY: begin
                if (mem.mem_ack)          state_n = S_DONE;
                else if (cnt == CNT_LAST) state_n = S_ERR;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt           <= '0;
            size_q        <= SZ_BYTE;
            off_q         <= '0;
            un_q          <= 1'b0;
            rw_q          <= RW_LOAD;
            rdata         <= '0;
            rsp_valid     <= 1'b0;
            err           <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wstrb <= '0;
            mem.mem_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (lane_bad) begin
                            rsp_valid <= 1'b1;
                            err       <= 1'b1;
                            rdata     <= '0;
                        end else begin
                            size_q        <= size_e'(access_size);
                            off_q         <= addr[1:0];
                            un_q          <= load_un;
                            rw_q          <= mem_rw;
                            cnt           <= '0;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= mem_rw;
                            mem.mem_addr  <= {addr[31:2], 2'b00};
                            mem.mem_wstrb <= (mem_rw == RW_STORE) ? lane_wstrb : 4'b0000;
                            mem.mem_wdata <= lane_wdata;
                        end
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + 8'd1;
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rdata       <= (rw_q == RW_STORE) ? '0 : lane_rdata;
                    end else if (cnt == CNT_LAST) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        rsp_valid   <= 1'b1;
                        err         <= 1'b1;
                        rdata       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with TIMEOUT = 4 and a scripted memory responder.
module tb_dmem_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        mem_rw;
    logic [1:0]  access_size;
    logic        load_un;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rsp_valid;
    logic        err;
    logic        stall;

    dmem_if mem ();

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .mem_rw      (mem_rw),
        .access_size (access_size),
        .load_un     (load_un),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rsp_valid   (rsp_valid),
        .err         (err),
        .stall       (stall),
        .mem         (mem)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    int          r_lat, r_nreq;
    logic        r_stall_ok, r_stall_rsp, r_err, r_we;
    logic [31:0] r_rd, r_wd, r_addr;
    logic [3:0]  r_strb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request; the memory acks on BUSY cycle ack_at (0 = never).
    task automatic run(input logic rw, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] mrd);
        logic got;
        got = 1'b0;
        r_lat = 0; r_nreq = 0; r_stall_ok = 1'b1; r_stall_rsp = 1'b1;
        r_rd = '0; r_err = 1'b0; r_strb = '0; r_wd = '0; r_we = 1'b0; r_addr = '0;
        req_valid = 1'b1; mem_rw = rw; access_size = sz; load_un = un;
        addr = a; wdata = wd; mem.mem_ack = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            #1;
            if (!stall) r_stall_ok = 1'b0;
            @(posedge clock); #1;
            if (mem.mem_req) begin
                r_nreq++;
                if (r_nreq == 1) begin
                    r_strb = mem.mem_wstrb; r_wd = mem.mem_wdata;
                    r_we = mem.mem_we; r_addr = mem.mem_addr;
                end
                mem.mem_ack = (r_nreq == ack_at);
                mem.mem_rdata = mrd;
            end else begin
                mem.mem_ack = 1'b0;
            end
            if (rsp_valid) begin
                got = 1'b1; r_lat = c; r_rd = rdata; r_err = err; r_stall_rsp = stall;
            end
        end
        if (!got) check("rsp_wait_expired", 32'd0, 32'd1);
        req_valid = 1'b0; mem.mem_ack = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; mem_rw = 1'b0; access_size = 2'b00;
        load_un = 1'b0; addr = '0; wdata = '0;
        mem.mem_ack = 1'b0; mem.mem_rdata = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_req", 32'(mem.mem_req), 32'd0);
        check("rst_mem_we", 32'(mem.mem_we), 32'd0);
        check("rst_mem_wstrb", 32'(mem.mem_wstrb), 32'h0);
        check("rst_mem_addr", mem.mem_addr, 32'h0);
        check("rst_mem_wdata", mem.mem_wdata, 32'h0);

        // Word load, ack on the 3rd BUSY cycle.
        run(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 3, 32'h8000_00FF);
        check("wl_rdata", r_rd, 32'h8000_00FF);
        check("wl_err", 32'(r_err), 32'd0);
        check("wl_latency", 32'(r_lat), 32'd4);
        check("wl_stall_before", 32'(r_stall_ok), 32'd1);
        check("wl_stall_at_rsp", 32'(r_stall_rsp), 32'd0);
        check("wl_mem_addr", r_addr, 32'h0000_0100);
        check("wl_wstrb", 32'(r_strb), 32'h0);
        check("wl_we", 32'(r_we), 32'd0);

        // Byte/half loads from 0x1234_80F6, minimum-latency ack.
        run(1'b0, 2'b00, 1'b0, 32'h0000_0202, 32'h0, 1, 32'h1234_80F6);
        check("lb_off2_rdata", r_rd, 32'h0000_0034);
        check("lb_off2_addr", r_addr, 32'h0000_0200);
        check("lb_min_latency", 32'(r_lat), 32'd2);
        run(1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 1, 32'h1234_80F6);
        check("lb_off0_rdata", r_rd, 32'hFFFF_FFF6);
        run(1'b0, 2'b00, 1'b1, 32'h0000_0200, 32'h0, 1, 32'h1234_80F6);
        check("lbu_off0_rdata", r_rd, 32'h0000_00F6);
        run(1'b0, 2'b00, 1'b0, 32'h0000_0201, 32'h0, 2, 32'h1234_80F6);
        check("lb_off1_rdata", r_rd, 32'hFFFF_FF80);
        run(1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0, 1, 32'h1234_80F6);
        check("lh_off0_rdata", r_rd, 32'hFFFF_80F6);
        run(1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0, 1, 32'h1234_80F6);
        check("lhu_off0_rdata", r_rd, 32'h0000_80F6);
        run(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 1, 32'h1234_80F6);
        check("lh_off2_rdata", r_rd, 32'h0000_1234);

        // Stores with wdata = 0xAABB_CCDD.
        run(1'b1, 2'b00, 1'b0, 32'h0000_0403, 32'hAABB_CCDD, 1, 32'hFFFF_FFFF);
        check("sb_off3_wstrb", 32'(r_strb), 32'h8);
        check("sb_off3_wdata", r_wd, 32'hDDDD_DDDD);
        check("sb_off3_we", 32'(r_we), 32'd1);
        check("sb_rdata_zero", r_rd, 32'h0);
        check("sb_err", 32'(r_err), 32'd0);
        run(1'b1, 2'b01, 1'b0, 32'h0000_0402, 32'hAABB_CCDD, 2, 32'h0);
        check("sh_off2_wstrb", 32'(r_strb), 32'hC);
        check("sh_off2_wdata", r_wd, 32'hCCDD_CCDD);
        run(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hAABB_CCDD, 1, 32'h0);
        check("sw_wstrb", 32'(r_strb), 32'hF);
        check("sw_wdata", r_wd, 32'hAABB_CCDD);

        // Misaligned and illegal requests.
        run(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 1, 32'h1111_1111);
        check("mis_word_err", 32'(r_err), 32'd1);
        check("mis_word_latency", 32'(r_lat), 32'd1);
        check("mis_word_no_req", 32'(r_nreq), 32'd0);
        check("mis_word_rdata", r_rd, 32'h0);
        run(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 1, 32'h1111_1111);
        check("mis_half_err", 32'(r_err), 32'd1);
        check("mis_half_no_req", 32'(r_nreq), 32'd0);
        run(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h1111_1111);
        check("ill_size_err", 32'(r_err), 32'd1);
        check("ill_size_latency", 32'(r_lat), 32'd1);
        check("ill_size_no_req", 32'(r_nreq), 32'd0);

        // Timeout, then ack racing the final BUSY cycle.
        run(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 0, 32'hDEAD_BEEF);
        check("tmo_req_cycles", 32'(r_nreq), 32'd4);
        check("tmo_err", 32'(r_err), 32'd1);
        check("tmo_rdata", r_rd, 32'h0);
        check("tmo_latency", 32'(r_lat), 32'd5);
        run(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 4, 32'hDEAD_BEEF);
        check("tmo_race_err", 32'(r_err), 32'd0);
        check("tmo_race_rdata", r_rd, 32'hDEAD_BEEF);
        check("tmo_race_latency", 32'(r_lat), 32'd5);

        // Reset while BUSY, then a stale ack.
        req_valid = 1'b1; mem_rw = 1'b0; access_size = 2'b10; load_un = 1'b0;
        addr = 32'h0000_0600;
        @(posedge clock); #1;
        check("rb_mem_req_busy", 32'(mem.mem_req), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; req_valid = 1'b0;
        check("rb_mem_req_drop", 32'(mem.mem_req), 32'd0);
        check("rb_no_rsp", 32'(rsp_valid), 32'd0);
        check("rb_ready", 32'(req_ready), 32'd1);
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h5555_5555;
        @(posedge clock); #1;
        mem.mem_ack = 1'b0;
        check("rb_stale_ack_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clock); #1;
        check("rb_stale_ack_rsp2", 32'(rsp_valid), 32'd0);
        check("rb_stale_ack_req", 32'(mem.mem_req), 32'd0);
        run(1'b0, 2'b00, 1'b0, 32'h0000_0602, 32'h0, 2, 32'h00AB_0000);
        check("rb_next_rdata", r_rd, 32'hFFFF_FFAB);
        check("rb_next_err", 32'(r_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
